// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, reset PC default and the
// response-state encoding used by the fetch unit.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FLOW  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_hold_buffer.sv
// One-entry buffer that parks the memory's read data when decode stalls, so
// the word survives while the memory moves on to the next address.
module fetch_hold_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  capture_i,
    input  logic  clear_i,
    input  word_t live_data_i,
    output word_t data_o,
    output logic  valid_o
);

    logic  hold_valid_q;
    word_t hold_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else if (clear_i) begin
            hold_valid_q <= 1'b0;
        end else if (capture_i) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= live_data_i;
        end
    end

    assign data_o  = hold_valid_q ? hold_data_q : live_data_i;
    assign valid_o = hold_valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch-stage requester: drives the word address to synchronous instruction
// memory and pairs each returned word with its PC at the IF/ID boundary.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter word_t       RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic [31:0] readAddress,
    input  logic [31:0] instructionData,
    output logic [31:0] fetchedInstruction,
    output logic [31:0] fetchedPC,
    output logic        fetchValid,
    output logic        fetchFault
);

    word_t        pc_q, pc_d;
    word_t        resp_pc_q, resp_pc_d;
    fetch_state_e state_q, state_d;

    logic hold_capture;
    logic hold_clear;
    logic hold_valid;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        state_d   = state_q;
        if (redirectValid) begin
            pc_d    = redirectTarget;
            state_d = ST_EMPTY;
        end else if (stall) begin
            if (state_q == ST_FLOW) begin
                state_d = ST_HOLD;
            end
        end else begin
            resp_pc_d = pc_q;
            pc_d      = pc_q + word_t'(1);
            state_d   = ST_FLOW;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= '0;
            state_q   <= ST_EMPTY;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            state_q   <= state_d;
        end
    end

    // Capture only on the first stalled cycle; later stalled cycles would
    // otherwise overwrite it with the word for pc, which is never emitted.
    assign hold_capture = stall && !redirectValid && (state_q == ST_FLOW);
    assign hold_clear   = redirectValid || !stall;

    fetch_hold_buffer u_hold (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (hold_capture),
        .clear_i     (hold_clear),
        .live_data_i (instructionData),
        .data_o      (fetchedInstruction),
        .valid_o     (hold_valid)
    );

    assign readAddress = pc_q;
    assign fetchedPC   = resp_pc_q;
    assign fetchValid  = (state_q != ST_EMPTY);
    assign fetchFault  = (state_q != ST_EMPTY) && (resp_pc_q >= word_t'(DEPTH));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized
// stall/redirect/reset traffic checked against a stream-level model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'd0;
    localparam int unsigned DEP = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectTarget = '0;
    logic [31:0] readAddress;
    logic [31:0] instructionData = '0;
    logic [31:0] fetchedInstruction;
    logic [31:0] fetchedPC;
    logic        fetchValid;
    logic        fetchFault;

    int total = 0;
    int bad   = 0;

    instruction_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEP)) dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .redirectValid      (redirectValid),
        .redirectTarget     (redirectTarget),
        .readAddress        (readAddress),
        .instructionData    (instructionData),
        .fetchedInstruction (fetchedInstruction),
        .fetchedPC          (fetchedPC),
        .fetchValid         (fetchValid),
        .fetchFault         (fetchFault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h100 + a;
    endfunction

    // Synchronous instruction memory: one-cycle read latency.
    always @(posedge clk) instructionData <= memf(readAddress);

    // Stream model: next PC to request, and the PC currently offered.
    logic [31:0] m_pc    = RPC;
    logic [31:0] m_opc   = '0;
    logic        m_valid = 1'b0;

    always @(negedge rst) begin
        m_pc    = RPC;
        m_opc   = '0;
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (redirectValid) begin
                m_pc    = redirectTarget;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_opc   = m_pc;
                m_pc    = m_pc + 32'd1;
                m_valid = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("readAddress", readAddress, m_pc);
        check("fetchValid", {31'd0, fetchValid}, {31'd0, m_valid});
        check("fetchFault", {31'd0, fetchFault}, {31'd0, m_valid && (m_opc >= DEP)});
        if (m_valid) begin
            check("fetchedPC", fetchedPC, m_opc);
            check("fetchedInstruction", fetchedInstruction, memf(m_opc));
        end else begin
            check("fetchedPC_idle", fetchedPC, rst ? fetchedPC : 32'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check({name, "_valid"}, {31'd0, fetchValid}, {31'd0, v});
        if (v) begin
            check({name, "_pc"}, fetchedPC, pc);
            check({name, "_ins"}, fetchedInstruction, ins);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, fetchValid}, 32'd0);
        check("rst_pc", fetchedPC, 32'd0);
        check("rst_addr", readAddress, RPC);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        step(); lit("boot0", 1'b1, 32'd0, 32'h100);
        step(); lit("boot1", 1'b1, 32'd1, 32'h101);
        step(); lit("boot2", 1'b1, 32'd2, 32'h102);

        stall = 1'b1;
        repeat (2) begin
            step(); lit("stall2", 1'b1, 32'd2, 32'h102);
        end
        stall = 1'b0;
        step(); lit("release3", 1'b1, 32'd3, 32'h103);

        redirectValid = 1'b1; redirectTarget = 32'd7;
        step(); redirectValid = 1'b0;
        lit("bubble7", 1'b0, 32'd0, 32'd0);
        step(); lit("redir7", 1'b1, 32'd7, 32'h107);
        step(); lit("redir8", 1'b1, 32'd8, 32'h108);

        stall = 1'b1;
        repeat (2) begin
            step(); lit("hold8", 1'b1, 32'd8, 32'h108);
        end
        redirectValid = 1'b1; redirectTarget = 32'd5;
        step(); redirectValid = 1'b0; stall = 1'b0;
        lit("bubble5", 1'b0, 32'd0, 32'd0);
        step(); lit("redir5", 1'b1, 32'd5, 32'h105);

        redirectValid = 1'b1; redirectTarget = 32'd9;
        step(); redirectValid = 1'b0;
        step(); lit("edge9", 1'b1, 32'd9, 32'h109);
        check("edge9_fault", {31'd0, fetchFault}, 32'd0);
        step(); lit("edge10", 1'b1, 32'd10, 32'h10a);
        check("edge10_fault", {31'd0, fetchFault}, 32'd1);

        stall = 1'b1;
        repeat (2) step();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", {31'd0, fetchValid}, 32'd0);
        check("midrst_fault", {31'd0, fetchFault}, 32'd0);
        check("midrst_pc", fetchedPC, 32'd0);
        check("midrst_addr", readAddress, RPC);
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(); lit("restart0", 1'b1, 32'd0, 32'h100);

        redirectValid = 1'b1; redirectTarget = 32'hFFFF_FFFF;
        step(); redirectValid = 1'b0;
        step(); lit("wrapTop", 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF);
        check("wrapTop_fault", {31'd0, fetchFault}, 32'd1);
        step(); lit("wrapZero", 1'b1, 32'd0, 32'h100);
        check("wrapZero_fault", {31'd0, fetchFault}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(199) == 0) begin
                #2 rst = 1'b0;
                stall = 1'b0;
                redirectValid = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                #1;
            end
            stall = ($urandom_range(9) < 4);
            redirectValid = ($urandom_range(9) == 0);
            case ($urandom_range(3))
                0:       redirectTarget = 32'hFFFF_FFFF - 32'($urandom_range(2));
                default: redirectTarget = 32'($urandom_range(13));
            endcase
        end

        stall = 1'b0;
        redirectValid = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
